// File: rtl/fp32_pkg.sv
// Shared constants, FSM state type and special-value helper for the FP32 divider.
package fp32_pkg;

   localparam int unsigned EXP_W     = 8;
   localparam int unsigned MAN_W     = 23;
   localparam int unsigned BIAS      = 127;
   localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
   localparam logic [MAN_W-1:0] QINF_MAN = 23'd0;
   localparam int unsigned DIV_ITERS = 25;

   typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} div_state_t;

   function automatic logic [EXP_W+MAN_W:0] inf_word(input logic sign);
      return {sign, EXP_MAX, QINF_MAN};
   endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp_div_step
#(
   parameter int unsigned SIG_W = 24
)(
   input  logic [SIG_W+1:0] r,
   input  logic [SIG_W-1:0] sig_b,
   output logic             qbit,
   output logic [SIG_W+1:0] r_next
);

   logic [SIG_W+1:0] divisor;
   logic [SIG_W+1:0] r_sel;

   // The remainder stays below 2*sig_b, so the shifted-out MSB is always zero.
   always_comb begin
      divisor = {2'b00, sig_b};
      qbit    = (r >= divisor);
      r_sel   = qbit ? (r - divisor) : r;
      r_next  = r_sel << 1;
   end

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider: radix-2 restoring, one quotient bit per cycle,
// start/done handshake, denormals flushed, exponent 255 treated as exception.
module fp32_div_seq
#(
   parameter int unsigned EXP_W = fp32_pkg::EXP_W,
   parameter int unsigned MAN_W = fp32_pkg::MAN_W,
   parameter int unsigned BIAS  = fp32_pkg::BIAS
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   res,
   output logic                   exception,
   output logic                   div_by_zero,
   output logic                   overflow,
   output logic                   underflow
);

   import fp32_pkg::*;

   localparam int unsigned W     = EXP_W + MAN_W + 1;
   localparam int unsigned SIG_W = MAN_W + 1;
   localparam int unsigned Q_W   = SIG_W + 1;
   localparam int unsigned R_W   = SIG_W + 2;
   localparam int unsigned E_W   = EXP_W + 2;
   localparam logic [E_W-1:0] BIAS_E    = E_W'(BIAS);
   localparam logic [E_W-1:0] E_OVF     = E_W'(EXP_MAX);
   localparam logic [4:0]     LAST_ITER = 5'(DIV_ITERS - 1);

   div_state_t state, state_nxt;

   logic [W-1:0]     a_q, b_q;
   logic             sign_q;
   logic [SIG_W-1:0] sig_b_q;
   logic [R_W-1:0]   r_q;
   logic [Q_W-1:0]   q_q;
   logic [4:0]       cnt_q;
   logic [E_W-1:0]   e_q;

   logic [EXP_W-1:0] ea, eb;
   logic [SIG_W-1:0] sig_a, sig_b;
   logic             sign_w, is_exc, b_zero, a_zero, special, shift;
   logic [R_W-1:0]   r_prep;
   logic [E_W-1:0]   e_prep;

   always_comb begin
      ea      = a_q[W-2 -: EXP_W];
      eb      = b_q[W-2 -: EXP_W];
      sig_a   = {ea != '0, a_q[MAN_W-1:0]};
      sig_b   = {eb != '0, b_q[MAN_W-1:0]};
      sign_w  = a_q[W-1] ^ b_q[W-1];
      is_exc  = (ea == EXP_MAX) || (eb == EXP_MAX);
      b_zero  = (eb == '0);
      a_zero  = (ea == '0);
      special = is_exc || b_zero || a_zero;
      shift   = (sig_a < sig_b);
      r_prep  = shift ? {1'b0, sig_a, 1'b0} : {2'b00, sig_a};
      e_prep  = E_W'(ea) - E_W'(eb) + BIAS_E - E_W'(shift);
   end

   logic           qbit;
   logic [R_W-1:0] r_step;

   fp_div_step #(.SIG_W(SIG_W)) u_step (
      .r      (r_q),
      .sig_b  (sig_b_q),
      .qbit   (qbit),
      .r_next (r_step)
   );

   logic             guard, sticky, up, carry, res_ovf, res_unf;
   logic [MAN_W:0]   frac_rnd;
   logic [MAN_W-1:0] man_rnd;
   logic [E_W-1:0]   e_rnd;

   // Q[24] is always 1, so a carry out of the stored fraction is the carry out of Q[24:1].
   always_comb begin
      guard    = q_q[0];
      sticky   = |r_q;
      up       = guard & (sticky | q_q[1]);
      frac_rnd = {1'b0, q_q[MAN_W:1]} + (MAN_W+1)'(up);
      carry    = frac_rnd[MAN_W] & q_q[Q_W-1];
      man_rnd  = carry ? '0 : frac_rnd[MAN_W-1:0];
      e_rnd    = carry ? (e_q + E_W'(1)) : e_q;
      res_ovf  = ($signed(e_rnd) >= $signed(E_OVF));
      res_unf  = e_rnd[E_W-1] || (e_rnd == '0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = special ? DONE : DIV;
         DIV:     if (cnt_q == LAST_ITER) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         res         <= '0;
         exception   <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         sig_b_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         e_q         <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state == PREP) || (state == DIV) || (state == ROUND);
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  a_q         <= a;
                  b_q         <= b;
                  exception   <= 1'b0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  underflow   <= 1'b0;
               end
            end
            PREP: begin
               sign_q  <= sign_w;
               sig_b_q <= sig_b;
               r_q     <= r_prep;
               q_q     <= '0;
               cnt_q   <= '0;
               e_q     <= e_prep;
               if (is_exc) begin
                  res       <= inf_word(sign_w);
                  exception <= 1'b1;
               end else if (b_zero) begin
                  res         <= inf_word(sign_w);
                  div_by_zero <= 1'b1;
               end else if (a_zero) begin
                  res <= '0;
               end
            end
            DIV: begin
               r_q   <= r_step;
               q_q   <= {q_q[Q_W-2:0], qbit};
               cnt_q <= cnt_q + 5'd1;
            end
            ROUND: begin
               if (res_ovf) begin
                  res      <= inf_word(sign_q);
                  overflow <= 1'b1;
               end else if (res_unf) begin
                  res       <= '0;
                  underflow <= 1'b1;
               end else begin
                  res <= {sign_q, e_rnd[EXP_W-1:0], man_rnd};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, res = a / b. It is the inverse-direction companion to the team's combinational FP32 multiplier.
- Uses the same special-case conventions as the multiplier:
  - exponent 255 on either operand is treated as exception (result infinity);
  - exponent 0 is treated as zero (denormals flushed).
- Radix-2 restoring iteration, one quotient bit per cycle.
- start/done handshake, so it can be issued by a datapath controller.

Parameters:
- EXP_W, 8, exponent width (only the default is supported).
- MAN_W, 23, stored mantissa width (only the default is supported).
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- a  in  32  dividend, captured on accept
- b  in  32  divisor, captured on accept
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; res and flags are valid from this cycle
- res  out  32  quotient, held until the next accept
- exception  out  1  an input had exponent 255
- div_by_zero  out  1  divisor exponent 0 and no exception
- overflow  out  1  result exponent >= 255
- underflow  out  1  result exponent <= 0

Behaviour:
- Reset: one clock, synchronous, active-low. When rst_n=0 at a clk edge:
  - state goes to IDLE;
  - busy, done, res and all flags go to 0.
  - This applies mid-operation too: the in-flight division is discarded and no done is issued.
- Accept: in IDLE with start=1, capture a and b and go to PREP. start while busy is ignored, with no effect on the current operation.
- PREP (1 cycle):
  - sign = a[31]^b[31].
  - Form sig = {exp!=0, man}.
  - Special-case priority:
    1. exception -> res={sign,8'hFF,23'd0}, exception=1.
    2. b zero -> res={sign,8'hFF,23'd0}, div_by_zero=1.
    3. a zero -> res=32'd0.
  - A special case goes directly to DONE.
  - Otherwise: if sig_a < sig_b, set R=sig_a<<1 and shift=1; else R=sig_a and shift=0. R is 26 bits.
  - e = ea - eb + BIAS - shift, computed signed, 10 bits.
- DIV (25 cycles): each cycle:
  - qbit = (R >= sig_b);
  - if qbit, R = R - sig_b;
  - R = R<<1;
  - Q = {Q[23:0], qbit}.
  - A 5-bit counter runs 0..24; on reaching 24, go to ROUND.
  - Q[24] is the leading 1 (guaranteed by the PREP normalisation). Q[0] is the guard bit. sticky = (R != 0).
- ROUND (1 cycle), round-to-nearest-even:
  - up = guard & (sticky | Q[1]).
  - m = Q[24:1] + up, 25 bits.
  - If m[24] (carry out of all-ones), mantissa = 0 and e = e+1.
  - If e >= 255: res={sign,8'hFF,23'd0}, overflow=1.
  - Else if e <= 0: res=32'd0, underflow=1.
  - Else res={sign,e[7:0],m[22:0]}.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
  - A start in the DONE cycle is ignored. It is accepted only in IDLE.
- Flags: cleared on each accept; at most one flag is set per result.
- Latency, with the accept edge as cycle 0:
  - special case: done at cycle 2;
  - normal: done at cycle 28.
- Throughput: one operation per 29 cycles (normal), 3 cycles (special).

Decomposition:
- Package fp32_pkg holds:
  - constants EXP_W, MAN_W, BIAS, EXP_MAX=8'hFF, QINF_MAN=23'd0;
  - the state enum {IDLE, PREP, DIV, ROUND, DONE};
  - the iteration count 25.
- Sub-module fp_div_step: combinational restoring step.
  - Inputs: R[25:0], sig_b[23:0].
  - Outputs: qbit, R_next[25:0].
  - Instantiated once inside the FSM datapath.

Test Plan:
1. 6.0/2.0: a=0x40C00000, b=0x40000000 -> res=0x40400000; done exactly 28 cycles after accept; all flags 0; busy high cycles 1..27.
2. 1.0/3.0 (shift path plus round-up): a=0x3F800000, b=0x40400000 -> res=0x3EAAAAAB, flags 0.
3. Sign handling: a=0xC0F00000 (-7.5), b=0x40200000 (2.5) -> res=0xC0400000.
4. Special cases, each with done at cycle 2:
   - a=0x3F800000, b=0x00000000 -> res=0x7F800000, div_by_zero=1.
   - a=0x7F800000, b=0x00000000 -> res=0x7F800000, exception=1, div_by_zero=0.
   - a=0x00000000, b=0x40000000 -> res=0x00000000.
5. Range limits:
   - a=0x7F000000, b=0x3E800000 -> res=0x7F800000, overflow=1.
   - a=0x00800000, b=0x4B000000 -> res=0x00000000, underflow=1.
6. Control:
   - start pulsed at cycles 5 and 27 of an operation -> ignored, first result unchanged.
   - rst_n=0 at cycle 10 of an operation -> next cycle busy=0, res=0, no done pulse.
   - A new start after reset completes normally.
